bram_s1s9_port_b_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 9-bit-wide port B of an X_RAMB16_S1_S9-class block RAM (2048 × 8 data + 2048 × 1 parity). Port A, the 1-bit port, is not touched by this block. After reset, the block can optionally zero-fill the whole port-B space. It then shares port B between requesters 0 and 1 using round-robin arbitration, with optional burst locking. Read data returns one cycle after grant, tagged to the requester.

---
 rtl/bram_s1s9_port_b_arbiter_pkg.sv | 15 +
 rtl/bram_s1s9_port_b_arbiter_rr_arb2.sv | 31 +++
 rtl/bram_s1s9_port_b_arbiter.sv | 134 +++++++++++++
 tb/tb_bram_s1s9_port_b_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_s1s9_port_b_arbiter_pkg.sv
// Shared types and geometry for the port-B arbiter of a 2048 x 9 (S9) block RAM port.
package bram_s1s9_port_b_arbiter_pkg;

  localparam int unsigned RAMB_S9_DEPTH = 2048;
  localparam int unsigned RAMB_S9_AW    = 11;
  localparam int unsigned RAMB_S9_DW    = 9;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StLock0,
    StLock1
  } state_e;

endpackage

// File: rtl/bram_s1s9_port_b_arbiter_rr_arb2.sv
// Two-input round-robin pick; on a tie the requester that did not win last time is granted.
module bram_s1s9_port_b_arbiter_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (upd_i && (gnt_o != 2'b00)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/bram_s1s9_port_b_arbiter.sv
// Port-B sequencer: optional zero-fill after reset, then round-robin sharing with burst lock
// and a one-entry read tag that steers RVALID to the requester one cycle after its grant.
module bram_s1s9_port_b_arbiter
  import bram_s1s9_port_b_arbiter_pkg::*;
#(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned ADDR_W         = RAMB_S9_AW
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic                  LOCK0,
  input  logic                  LOCK1,
  input  logic [ADDR_W-1:0]     ADDR0,
  input  logic [ADDR_W-1:0]     ADDR1,
  input  logic [RAMB_S9_DW-1:0] DI0,
  input  logic [RAMB_S9_DW-1:0] DI1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  RVALID0,
  output logic                  RVALID1,
  output logic [RAMB_S9_DW-1:0] RDATA,
  output logic                  BUSY,
  output logic                  ENB,
  output logic                  WEB,
  output logic                  SSRB,
  output logic [ADDR_W-1:0]     ADDRB,
  output logic [7:0]            DIB,
  output logic                  DIPB,
  input  logic [7:0]            DOB,
  input  logic                  DOPB
);

  localparam state_e StReset = CLEAR_ON_RESET ? StClear : StIdle;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(RAMB_S9_DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              tag_valid_q, tag_valid_d;
  logic              tag_id_q, tag_id_d;
  logic [1:0]        arb_req, gnt;

  // Lock states expose only the owner to the arbiter; reset masks everything.
  always_comb begin
    arb_req = 2'b00;
    if (!RST) begin
      unique case (state_q)
        StIdle:  arb_req = {REQ1, REQ0};
        StLock0: arb_req = {1'b0, REQ0};
        StLock1: arb_req = {REQ1, 1'b0};
        default: arb_req = 2'b00;
      endcase
    end
  end

  bram_s1s9_port_b_arbiter_rr_arb2 u_rr_arb2 (
    .clk_i (CLK),
    .rst_i (RST),
    .req_i (arb_req),
    .upd_i (state_q != StClear),
    .gnt_o (gnt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StReset;
      cnt_q       <= '0;
      tag_valid_q <= 1'b0;
      tag_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastAddr) state_d = StIdle;
      end
      StIdle: begin
        if (gnt[0] && LOCK0)      state_d = StLock0;
        else if (gnt[1] && LOCK1) state_d = StLock1;
      end
      StLock0: if (!REQ0 || !LOCK0) state_d = StIdle;
      StLock1: if (!REQ1 || !LOCK1) state_d = StIdle;
      default: state_d = StReset;
    endcase
  end

  always_comb begin
    ENB   = 1'b0;
    WEB   = 1'b0;
    ADDRB = '0;
    DIB   = '0;
    DIPB  = 1'b0;
    if (!RST && state_q == StClear) begin
      ENB   = 1'b1;
      WEB   = 1'b1;
      ADDRB = cnt_q;
    end else if (gnt[0]) begin
      ENB   = 1'b1;
      WEB   = WE0;
      ADDRB = ADDR0;
      DIB   = DI0[7:0];
      DIPB  = DI0[8];
    end else if (gnt[1]) begin
      ENB   = 1'b1;
      WEB   = WE1;
      ADDRB = ADDR1;
      DIB   = DI1[7:0];
      DIPB  = DI1[8];
    end
    tag_valid_d = (gnt != 2'b00) && !WEB;
    tag_id_d    = gnt[1];
  end

  assign GNT0    = gnt[0];
  assign GNT1    = gnt[1];
  assign RVALID0 = tag_valid_q && !tag_id_q;
  assign RVALID1 = tag_valid_q && tag_id_q;
  assign RDATA   = {DOPB, DOB};
  assign BUSY    = (state_q == StClear);
  assign SSRB    = 1'b0;

endmodule

// File: tb/tb_bram_s1s9_port_b_arbiter.sv
// Directed bench for the port-B arbiter with a behavioural 2048 x 9 RAM attached to port B.
module tb_bram_s1s9_port_b_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0, REQ1, WE0, WE1, LOCK0, LOCK1;
  logic [10:0] ADDR0, ADDR1;
  logic [8:0]  DI0, DI1;
  logic        GNT0, GNT1, RVALID0, RVALID1, BUSY, ENB, WEB, SSRB, DIPB, DOPB;
  logic [8:0]  RDATA;
  logic [10:0] ADDRB;
  logic [7:0]  DIB, DOB;

  logic [8:0]  mem [0:2047];
  logic        do_preload;
  int          total = 0;
  int          bad = 0;
  int          n;
  int          nz;

  always #5 CLK = ~CLK;

  bram_s1s9_port_b_arbiter dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ0    (REQ0),
    .REQ1    (REQ1),
    .WE0     (WE0),
    .WE1     (WE1),
    .LOCK0   (LOCK0),
    .LOCK1   (LOCK1),
    .ADDR0   (ADDR0),
    .ADDR1   (ADDR1),
    .DI0     (DI0),
    .DI1     (DI1),
    .GNT0    (GNT0),
    .GNT1    (GNT1),
    .RVALID0 (RVALID0),
    .RVALID1 (RVALID1),
    .RDATA   (RDATA),
    .BUSY    (BUSY),
    .ENB     (ENB),
    .WEB     (WEB),
    .SSRB    (SSRB),
    .ADDRB   (ADDRB),
    .DIB     (DIB),
    .DIPB    (DIPB),
    .DOB     (DOB),
    .DOPB    (DOPB)
  );

  // RAM model: synchronous read, preloaded with nonzero contents so the clear is visible.
  always @(posedge CLK) begin
    if (do_preload) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 9'h100 | 9'(i & 8'hff);
    end else if (ENB) begin
      if (WEB) mem[ADDRB] <= {DIPB, DIB};
      else     {DOPB, DOB} <= mem[ADDRB];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; do_preload = 1'b1;
    REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0; LOCK0 = 0; LOCK1 = 0;
    ADDR0 = '0; ADDR1 = '0; DI0 = '0; DI1 = '0;
    repeat (2) @(negedge CLK);
    do_preload = 1'b0;

    // Reset values, with a request already pending.
    REQ0 = 1; WE0 = 0; ADDR0 = 11'd0;
    #1;
    chk("rst_gnt0", GNT0, 0);
    chk("rst_enb", ENB, 0);
    chk("rst_web", WEB, 0);
    chk("rst_addrb", ADDRB, 0);
    chk("rst_busy", BUSY, 1);
    chk("rst_rvalid0", RVALID0, 0);
    chk("rst_ssrb", SSRB, 0);

    // Clear after reset: 2048 busy cycles, request held.
    @(negedge CLK);
    RST = 0;
    n = 0;
    while (BUSY === 1'b1 && n < 5000) begin
      if (n == 1000) begin
        chk("clr_gnt_held", GNT0, 0);
        chk("clr_enb_web", {ENB, WEB}, 2'b11);
        chk("clr_addrb", ADDRB, 1000);
      end
      @(negedge CLK);
      n++;
    end
    chk("clear_len", n, 2048);
    chk("first_idle_gnt0", GNT0, 1);
    chk("first_idle_addr", ADDRB, 0);
    nz = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== 9'h000) nz++;
    chk("clear_all_zero", nz, 0);
    @(negedge CLK);
    REQ0 = 0;
    chk("first_rd_rvalid0", RVALID0, 1);
    chk("first_rd_rdata", RDATA, 9'h000);

    // Seed addresses 10 and 20.
    REQ0 = 1; WE0 = 1; ADDR0 = 11'd10; DI0 = 9'h0AB;
    #1;
    chk("wr10_gnt0", GNT0, 1);
    chk("wr10_dib", {DIPB, DIB}, 9'h0AB);
    @(negedge CLK);
    REQ0 = 0; WE0 = 0;
    REQ1 = 1; WE1 = 1; ADDR1 = 11'd20; DI1 = 9'h1CD;
    #1;
    chk("wr20_gnt1", GNT1, 1);
    chk("wr20_dib", {DIPB, DIB}, 9'h1CD);
    chk("wr_no_rvalid0", RVALID0, 0);
    @(negedge CLK);
    REQ1 = 0; WE1 = 0;
    chk("wr_no_rvalid1", RVALID1, 0);

    // Both reading continuously: grants alternate 0,1,0,1.
    REQ0 = 1; ADDR0 = 11'd10; REQ1 = 1; ADDR1 = 11'd20;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_gnt0", GNT0, (k % 2) == 0);
      chk("rr_gnt1", GNT1, (k % 2) == 1);
      if (k > 0) begin
        chk("rr_rvalid0", RVALID0, ((k - 1) % 2) == 0);
        chk("rr_rdata", RDATA, ((k - 1) % 2) == 0 ? 9'h0AB : 9'h1CD);
      end
      @(negedge CLK);
    end
    REQ0 = 0; REQ1 = 0;
    chk("rr_last_rvalid1", RVALID1, 1);
    chk("rr_last_rdata", RDATA, 9'h1CD);

    // Write then immediate read by the other requester.
    REQ0 = 1; WE0 = 1; ADDR0 = 11'd5; DI0 = 9'h1A5;
    #1;
    chk("wr5_gnt0", GNT0, 1);
    @(negedge CLK);
    REQ0 = 0; WE0 = 0;
    REQ1 = 1; WE1 = 0; ADDR1 = 11'd5;
    #1;
    chk("rd5_gnt1", GNT1, 1);
    @(negedge CLK);
    REQ1 = 0;
    chk("rd5_rvalid1", RVALID1, 1);
    chk("rd5_rdata", RDATA, 9'h1A5);
    chk("rd5_dopb", DOPB, 1);

    // Burst lock by requester 0 while requester 1 waits.
    REQ1 = 1; WE1 = 0; ADDR1 = 11'd20;
    REQ0 = 1; WE0 = 1;
    for (int k = 0; k < 4; k++) begin
      ADDR0 = 11'(100 + k); DI0 = 9'(k); LOCK0 = (k < 3);
      #1;
      chk("lock_gnt0", GNT0, 1);
      chk("lock_gnt1", GNT1, 0);
      @(negedge CLK);
    end
    REQ0 = 0; WE0 = 0; LOCK0 = 0;
    #1;
    chk("unlock_gnt1", GNT1, 1);
    chk("unlock_gnt0", GNT0, 0);
    @(negedge CLK);
    REQ1 = 0;
    chk("unlock_rvalid1", RVALID1, 1);
    chk("unlock_rdata", RDATA, 9'h1CD);

    // Reset one cycle after a read grant drops the pending RVALID.
    REQ0 = 1; WE0 = 0; ADDR0 = 11'd10;
    #1;
    chk("pre_rst_gnt0", GNT0, 1);
    @(posedge CLK);
    #1;
    RST = 1;
    #1;
    chk("rst_drop_rvalid0", RVALID0, 0);
    @(negedge CLK);
    #1;
    chk("rst2_gnt0", GNT0, 0);
    chk("rst2_enb_web", {ENB, WEB}, 2'b00);
    chk("rst2_addrb", ADDRB, 0);
    chk("rst2_di", {DIPB, DIB}, 9'h000);
    chk("rst2_rvalid", {RVALID1, RVALID0}, 2'b00);
    chk("rst2_busy", BUSY, 1);
    @(negedge CLK);
    chk("rst3_rvalid0", RVALID0, 0);

    // Reset pulse mid-clear restarts the full 2048-cycle clear.
    RST = 0; REQ0 = 0;
    repeat (1000) @(negedge CLK);
    chk("midclr_addrb", ADDRB, 1000);
    chk("midclr_busy", BUSY, 1);
    RST = 1;
    #1;
    chk("midclr_rst_addrb", ADDRB, 0);
    @(negedge CLK);
    RST = 0;
    n = 0;
    while (BUSY === 1'b1 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    chk("reclear_len", n, 2048);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
